// File: rtl/lc3b_mem_stage.sv
// LC-3b MEM stage: sequences data-memory accesses (incl. LDI/STI indirection), registers MEM_WB.
// Control bundle bit 0 = mem_read_d, bit 1 = mem_write, bit 2 = isI.
module lc3b_mem_stage #(
  parameter int unsigned WORD_ALIGN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_mem_valid,
  input  logic [88:0] ex_mem,
  input  logic        flush,
  output logic [15:0] dmem_addr,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [15:0] dmem_wdata,
  output logic [1:0]  dmem_byte_enable,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic [88:0] mem_wb,
  output logic        mem_wb_valid,
  output logic        stall
);

  localparam int unsigned CtrlMemRead  = 0;
  localparam int unsigned CtrlMemWrite = 1;
  localparam int unsigned CtrlIsI      = 2;

  typedef enum logic [1:0] {StIdle, StAccess, StPtr, StAccess2} state_e;

  state_e      state_q, state_d;
  logic [15:0] ptr_q, ptr_d;
  logic        gap_q, gap_d;
  logic        flushed_q, flushed_d;
  logic [88:0] mem_wb_q, mem_wb_d;
  logic        mem_wb_valid_q, mem_wb_valid_d;

  logic [24:0] ctrl;
  logic [15:0] pc, alu, srcb, intr;
  logic        rd_op, wr_op, ind_op, byte_op, mem_op, kill;
  logic        strobe_rd, strobe_wr, use_ptr, stall_c, load;
  logic [15:0] base_addr, rd_sel, mem_data;

  assign ctrl    = ex_mem[88:64];
  assign pc      = ex_mem[63:48];
  assign alu     = ex_mem[47:32];
  assign srcb    = ex_mem[31:16];
  assign intr    = ex_mem[15:0];
  assign rd_op   = ctrl[CtrlMemRead];
  assign wr_op   = ctrl[CtrlMemWrite];
  assign ind_op  = ctrl[CtrlIsI];
  assign byte_op = (intr[15:12] == 4'b0010) || (intr[15:12] == 4'b0011);
  assign mem_op  = rd_op | wr_op;
  assign kill    = flush | flushed_q;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gap_d     = 1'b0;
    strobe_rd = 1'b0;
    strobe_wr = 1'b0;
    use_ptr   = 1'b0;
    stall_c   = 1'b0;
    load      = 1'b0;
    mem_wb_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ex_mem_valid && mem_op && !flush) begin
          // The first access of an indirect op is always the pointer read.
          strobe_rd = rd_op | ind_op;
          strobe_wr = ~(rd_op | ind_op);
          stall_c   = 1'b1;
          state_d   = ind_op ? StPtr : StAccess;
        end else begin
          load           = 1'b1;
          mem_wb_valid_d = ex_mem_valid && !flush && !mem_op;
        end
      end
      StAccess: begin
        strobe_rd = rd_op;
        strobe_wr = ~rd_op;
        stall_c   = ~dmem_resp;
        if (dmem_resp) begin
          load           = 1'b1;
          mem_wb_valid_d = ~kill;
          state_d        = StIdle;
        end
      end
      StPtr: begin
        strobe_rd = 1'b1;
        stall_c   = ~(dmem_resp && kill);
        if (dmem_resp) begin
          ptr_d   = dmem_rdata;
          state_d = kill ? StIdle : StAccess2;
          gap_d   = ~kill;
        end
      end
      StAccess2: begin
        use_ptr = 1'b1;
        if (gap_q) begin
          // Strobe-free turnaround cycle; a flush here cancels the second access.
          stall_c = ~kill;
          if (kill) state_d = StIdle;
        end else begin
          strobe_rd = rd_op;
          strobe_wr = ~rd_op;
          stall_c   = ~dmem_resp;
          if (dmem_resp) begin
            load           = 1'b1;
            mem_wb_valid_d = ~kill;
            state_d        = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    flushed_d = (state_q != StIdle) && (state_d != StIdle) && kill;
  end

  always_comb begin
    base_addr = use_ptr ? ptr_q : alu;
    dmem_addr = base_addr;
    if (WORD_ALIGN != 0 && !byte_op) dmem_addr[0] = 1'b0;
    dmem_wdata       = byte_op ? {srcb[7:0], srcb[7:0]} : srcb;
    dmem_byte_enable = byte_op ? (dmem_addr[0] ? 2'b10 : 2'b01) : 2'b11;
    rd_sel   = byte_op ? {8'h00, (dmem_addr[0] ? dmem_rdata[15:8] : dmem_rdata[7:0])}
                       : dmem_rdata;
    mem_data = (state_q != StIdle && rd_op) ? rd_sel : 16'h0000;
    mem_wb_d = load ? {ctrl, mem_data, pc, alu, intr} : mem_wb_q;
  end

  // Gated by reset so the strobes and stall drop without waiting for a clock.
  assign dmem_read    = strobe_rd & rst_n;
  assign dmem_write   = strobe_wr & rst_n;
  assign stall        = stall_c & rst_n;
  assign mem_wb       = mem_wb_q;
  assign mem_wb_valid = mem_wb_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      ptr_q          <= 16'h0000;
      gap_q          <= 1'b0;
      flushed_q      <= 1'b0;
      mem_wb_q       <= '0;
      mem_wb_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      gap_q          <= gap_d;
      flushed_q      <= flushed_d;
      mem_wb_q       <= mem_wb_d;
      mem_wb_valid_q <= mem_wb_valid_d;
    end
  end

endmodule

// File: tb/tb_lc3b_mem_stage.sv
// Scoreboard bench for lc3b_mem_stage: directed ops, a latency-programmable memory responder.
module tb_lc3b_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_mem_valid = 1'b0;
  logic [88:0] ex_mem = '0;
  logic        flush = 1'b0;
  logic [15:0] dmem_addr;
  logic        dmem_read, dmem_write;
  logic [15:0] dmem_wdata;
  logic [1:0]  dmem_byte_enable;
  logic [15:0] dmem_rdata = '0;
  logic        dmem_resp;
  logic [88:0] mem_wb;
  logic        mem_wb_valid, stall;

  logic resp_m = 1'b0, resp_x = 1'b0;
  assign dmem_resp = resp_m | resp_x;

  lc3b_mem_stage #(.WORD_ALIGN(1)) dut (
    .clk(clk), .rst_n(rst_n), .ex_mem_valid(ex_mem_valid), .ex_mem(ex_mem), .flush(flush),
    .dmem_addr(dmem_addr), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_wdata(dmem_wdata), .dmem_byte_enable(dmem_byte_enable), .dmem_rdata(dmem_rdata),
    .dmem_resp(dmem_resp), .mem_wb(mem_wb), .mem_wb_valid(mem_wb_valid), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
    logic [1:0]  be;
  } acc_t;

  int          checks = 0;
  int          errors = 0;
  int          mem_lat = 2;
  int          cnt = 0;
  logic [88:0] sb_q[$];
  logic [15:0] rd_q[$];
  acc_t        acc_q[$];

  task automatic chk(input string nm, input logic [88:0] act, input logic [88:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Memory responder: resp on the mem_lat-th consecutive strobe cycle.
  always @(negedge clk) begin
    if (resp_m) begin
      resp_m = 1'b0;
      cnt = 0;
    end
    if (!rst_n) cnt = 0;
    else if (dmem_read || dmem_write) begin
      cnt++;
      if (cnt >= mem_lat) begin
        resp_m = 1'b1;
        dmem_rdata = (rd_q.size() > 0) ? rd_q.pop_front() : 16'h0000;
        acc_q.push_back('{dmem_addr, dmem_write, dmem_wdata, dmem_byte_enable});
      end
    end else cnt = 0;
  end

  // Monitor: every MEM_WB pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && mem_wb_valid) begin
      if (sb_q.size() == 0) chk("unexpected_mem_wb_valid", 89'(mem_wb_valid), 89'(0));
      else chk("mem_wb", mem_wb, sb_q.pop_front());
    end
  end

  // Called at posedge+1; returns at posedge+1 after the cycle where stall was low.
  task automatic issue(input logic [24:0] c, input logic [15:0] pc, input logic [15:0] alu,
                       input logic [15:0] srcb, input logic [15:0] intr, input int lat,
                       input int fl_cyc, output int stall_cnt, output int gap_cnt);
    logic s, done;
    done = 1'b0;
    stall_cnt = 0;
    gap_cnt = 0;
    mem_lat = lat;
    ex_mem = {c, pc, alu, srcb, intr};
    ex_mem_valid = 1'b1;
    for (int cy = 0; cy < 60; cy++) begin
      flush = (cy == fl_cyc);
      @(negedge clk);
      #4;
      if (dmem_read && dmem_write) chk("both_strobes", 89'(1), 89'(0));
      s = stall;
      if (stall && !dmem_read && !dmem_write) gap_cnt++;
      @(posedge clk);
      #1;
      if (!s) begin
        done = 1'b1;
        break;
      end
      stall_cnt++;
    end
    flush = 1'b0;
    ex_mem_valid = 1'b0;
    if (!done) chk("issue_timeout", 89'(0), 89'(1));
  endtask

  task automatic chk_acc(input string nm, input logic [15:0] addr, input logic we,
                         input logic [15:0] wdata, input logic [1:0] be);
    acc_t a;
    if (acc_q.size() == 0) begin
      chk({nm, "_missing"}, 89'(0), 89'(1));
      return;
    end
    a = acc_q.pop_front();
    chk({nm, "_addr"}, 89'(a.addr), 89'(addr));
    chk({nm, "_we"}, 89'(a.we), 89'(we));
    if (we) begin
      chk({nm, "_wdata"}, 89'(a.wdata), 89'(wdata));
      chk({nm, "_be"}, 89'(a.be), 89'(be));
    end
  endtask

  initial begin
    int sc, gc;
    #12;
    chk("rst_mem_wb", mem_wb, 89'(0));
    chk("rst_valid", 89'(mem_wb_valid), 89'(0));
    chk("rst_read", 89'(dmem_read), 89'(0));
    chk("rst_write", 89'(dmem_write), 89'(0));
    chk("rst_stall", 89'(stall), 89'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ADD: one-cycle pass-through, no stall
    sb_q.push_back({25'h12340, 16'h0000, 16'h0100, 16'h0007, 16'h1042});
    issue(25'h12340, 16'h0100, 16'h0007, 16'h0000, 16'h1042, 2, -1, sc, gc);
    chk("add_stall", 89'(sc), 89'(0));

    // LDR at 0x3005: aligned to 0x3004, three stall cycles
    rd_q.push_back(16'hBEEF);
    sb_q.push_back({25'h00101, 16'hBEEF, 16'h0102, 16'h3005, 16'h6283});
    issue(25'h00101, 16'h0102, 16'h3005, 16'h0000, 16'h6283, 4, -1, sc, gc);
    chk("ldr_stall", 89'(sc), 89'(3));
    chk_acc("ldr", 16'h3004, 1'b0, 16'h0, 2'b00);

    // LDB at 0x3005: high byte zero-extended
    rd_q.push_back(16'hA17C);
    sb_q.push_back({25'h00001, 16'h00A1, 16'h0104, 16'h3005, 16'h2283});
    issue(25'h00001, 16'h0104, 16'h3005, 16'h0000, 16'h2283, 2, -1, sc, gc);
    chk_acc("ldb", 16'h3005, 1'b0, 16'h0, 2'b00);

    // STB at 0x3004 and 0x3007
    sb_q.push_back({25'h00002, 16'h0000, 16'h0106, 16'h3004, 16'h3283});
    issue(25'h00002, 16'h0106, 16'h3004, 16'h1234, 16'h3283, 3, -1, sc, gc);
    chk_acc("stb_even", 16'h3004, 1'b1, 16'h3434, 2'b01);
    sb_q.push_back({25'h00002, 16'h0000, 16'h0108, 16'h3007, 16'h3283});
    issue(25'h00002, 16'h0108, 16'h3007, 16'h00AB, 16'h3283, 2, -1, sc, gc);
    chk_acc("stb_odd", 16'h3007, 1'b1, 16'hABAB, 2'b10);

    // STI: pointer read, one strobe-free cycle, word write at pointer
    rd_q.push_back(16'h5002);
    sb_q.push_back({25'h00006, 16'h0000, 16'h010A, 16'h4000, 16'hB283});
    issue(25'h00006, 16'h010A, 16'h4000, 16'h00FF, 16'hB283, 2, -1, sc, gc);
    chk("sti_stall", 89'(sc), 89'(4));
    chk("sti_gap", 89'(gc), 89'(1));
    chk_acc("sti_ptr", 16'h4000, 1'b0, 16'h0, 2'b00);
    chk_acc("sti_wr", 16'h5002, 1'b1, 16'h00FF, 2'b11);

    // LDI flushed during PTR: pointer read completes, nothing else
    rd_q.push_back(16'h7000);
    issue(25'h00005, 16'h010C, 16'h6001, 16'h0000, 16'hA283, 3, 1, sc, gc);
    chk("ldi_flush_stall", 89'(sc), 89'(2));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #4;
      chk("ldi_flush_idle", {stall, dmem_read, dmem_write}, 89'(0));
    end
    chk_acc("ldi_flush_ptr", 16'h6000, 1'b0, 16'h0, 2'b00);
    chk("ldi_flush_accesses", 89'(acc_q.size()), 89'(0));
    @(posedge clk);
    #1;

    // Reset mid-ACCESS, then a late resp must be ignored
    mem_lat = 20;
    ex_mem = {25'h00001, 16'h0110, 16'h2222, 16'h0000, 16'h6283};
    ex_mem_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #4;
    chk("pre_rst_read", 89'(dmem_read), 89'(1));
    rst_n = 1'b0;
    #1;
    chk("async_rst", {dmem_read, dmem_write, stall, mem_wb_valid}, 89'(0));
    ex_mem_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    resp_x = 1'b1;
    @(negedge clk);
    #1;
    resp_x = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #4;
      chk("late_resp_ignored", {mem_wb_valid, stall, dmem_read}, 89'(0));
    end
    @(posedge clk);
    #1;

    // Recovery: a plain LDR after reset
    rd_q.push_back(16'h1357);
    sb_q.push_back({25'h00001, 16'h1357, 16'h0112, 16'h0020, 16'h6283});
    issue(25'h00001, 16'h0112, 16'h0020, 16'h0000, 16'h6283, 2, -1, sc, gc);
    chk("recov_stall", 89'(sc), 89'(1));
    chk_acc("recov", 16'h0020, 1'b0, 16'h0, 2'b00);

    repeat (3) @(posedge clk);
    chk("sb_drained", 89'(sb_q.size()), 89'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
